seq_muldiv: RTL

//  Parametrised iterative signed multiply/divide unit for the CPU datapath (MIPS-style HI/LO).

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_addsub.sv | 23 ++
 rtl/seq_muldiv.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM state type and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// N-bit combinational add/subtract (sub=1 gives x - y), shared by the Booth
// step and the restoring-division trial subtraction.
module muldiv_addsub #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum
);

  logic [N-1:0] y_eff;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_inv
      assign y_eff[gi] = y[gi] ^ sub;
    end
  endgenerate

  assign sum = x + y_eff + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/seq_muldiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) with HI/LO results.
// Optional build macro MULDIV_DIV0_FLAG_EN adds the div0 output flag.
module seq_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam int AW    = WIDTH + 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             op_reg, op_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [AW-1:0]    acc_reg, acc_next;     // Booth accumulator / division remainder
  logic [WIDTH-1:0] q_reg, q_next;         // Booth multiplier / division quotient
  logic             qm1_reg, qm1_next;
  logic [AW-1:0]    m_reg, m_next;         // sign-extended multiplicand / |divisor|
  logic             neg_quo_reg, neg_quo_next;
  logic             neg_rem_reg, neg_rem_next;
  logic             div0_reg, div0_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;
`ifdef MULDIV_DIV0_FLAG_EN
  logic             div0_flag_reg, div0_flag_next;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [1:0]       booth_pair;
  logic [AW-1:0]    booth_acc;
  logic [AW-1:0]    rem_sh;
  logic [AW-1:0]    add_x;
  logic             add_sub;
  logic [AW-1:0]    sum;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign a_mag = a[WIDTH-1] ? WIDTH'(-a) : a;
  assign b_mag = b[WIDTH-1] ? WIDTH'(-b) : b;

  assign booth_pair = {q_reg[0], qm1_reg};
  assign rem_sh     = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign add_x      = (op_reg == OP_DIV) ? rem_sh : acc_reg;
  assign add_sub    = (op_reg == OP_DIV) ? 1'b1 : (booth_pair == 2'b10);

  muldiv_addsub #(.N(AW)) u_addsub (
    .x   (add_x),
    .y   (m_reg),
    .sub (add_sub),
    .sum (sum)
  );

  assign booth_acc = (booth_pair == 2'b01 || booth_pair == 2'b10) ? sum : acc_reg;
  assign quo_fix   = neg_quo_reg ? WIDTH'(-q_reg) : q_reg;
  assign rem_fix   = neg_rem_reg ? WIDTH'(-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    op_next      = op_reg;
    a_next       = a_reg;
    acc_next     = acc_reg;
    q_next       = q_reg;
    qm1_next     = qm1_reg;
    m_next       = m_reg;
    neg_quo_next = neg_quo_reg;
    neg_rem_next = neg_rem_reg;
    div0_next    = div0_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    done_next    = 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
    div0_flag_next = 1'b0;
`endif
    busy = (state_reg != IDLE);

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          cnt_next     = '0;
          op_next      = op;
          a_next       = a;
          acc_next     = '0;
          qm1_next     = 1'b0;
          neg_quo_next = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_next = a[WIDTH-1];
          div0_next    = (op == OP_DIV) && (b == '0);
          if (op == OP_DIV) begin
            q_next = a_mag;
            m_next = {1'b0, b_mag};
          end else begin
            q_next = b;
            m_next = {a[WIDTH-1], a};
          end
        end
      end
      RUN: begin
        if (op_reg == OP_DIV) begin
          // Keep the trial difference only when it did not go negative.
          acc_next = sum[WIDTH] ? rem_sh : sum;
          q_next   = {q_reg[WIDTH-2:0], ~sum[WIDTH]};
        end else begin
          acc_next = {booth_acc[WIDTH], booth_acc[WIDTH:1]};
          q_next   = {booth_acc[0], q_reg[WIDTH-1:1]};
          qm1_next = q_reg[0];
        end
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (op_reg == OP_MULT) begin
          hi_next = acc_reg[WIDTH-1:0];
          lo_next = q_reg;
        end else if (div0_reg) begin
          hi_next = a_reg;
          lo_next = '1;
        end else begin
          hi_next = rem_fix;
          lo_next = quo_fix;
        end
`ifdef MULDIV_DIV0_FLAG_EN
        div0_flag_next = div0_reg;
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_reg      <= OP_MULT;
      a_reg       <= '0;
      acc_reg     <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      m_reg       <= '0;
      neg_quo_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      op_reg      <= op_next;
      a_reg       <= a_next;
      acc_reg     <= acc_next;
      q_reg       <= q_next;
      qm1_reg     <= qm1_next;
      m_reg       <= m_next;
      neg_quo_reg <= neg_quo_next;
      neg_rem_reg <= neg_rem_next;
      div0_reg    <= div0_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      done_reg    <= done_next;
    end
  end

`ifdef MULDIV_DIV0_FLAG_EN
  always_ff @(posedge clock) begin
    if (reset) div0_flag_reg <= 1'b0;
    else       div0_flag_reg <= div0_flag_next;
  end
  assign div0 = div0_flag_reg;
`endif

  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
